// File: rtl/audio_fx_pkg.sv
// Shared types and helpers for the audio effect processor: mode codes, FSM states,
// and a width-parametrised saturating adder.
package audio_fx_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_MUTE = 2'd1,
    MODE_SWAP = 2'd2,
    MODE_ECHO = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_MIX   = 2'd2,
    ST_SEND  = 2'd3
  } state_e;

  localparam int SAT_W = 64;

  // Adds two sign-extended operands and clamps the result to a signed w-bit range.
  function automatic logic signed [SAT_W-1:0] sat_add(
    input  logic signed [SAT_W-1:0] a,
    input  logic signed [SAT_W-1:0] b,
    input  int                      w,
    output logic                    sat
  );
    logic signed [SAT_W-1:0] sum;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sum = a + b;
    hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (w - 1));
    sat = 1'b0;
    if (sum > hi) begin
      sat = 1'b1;
      return hi;
    end else if (sum < lo) begin
      sat = 1'b1;
      return lo;
    end
    return sum;
  endfunction

endpackage

// File: rtl/audio_stream_fx_if.sv
// Codec-side read/write handshake bundle; master is the effect processor, slave the codec.
interface audio_stream_fx_if #(
  parameter int DATA_W = 24
);
  logic              read_ready;
  logic [DATA_W-1:0] readdata_left;
  logic [DATA_W-1:0] readdata_right;
  logic              read;
  logic              write_ready;
  logic              write;
  logic [DATA_W-1:0] writedata_left;
  logic [DATA_W-1:0] writedata_right;

  modport master (
    input  read_ready, readdata_left, readdata_right, write_ready,
    output read, write, writedata_left, writedata_right
  );

  modport slave (
    output read_ready, readdata_left, readdata_right, write_ready,
    input  read, write, writedata_left, writedata_right
  );
endinterface

// File: rtl/audio_delay_ram.sv
// Simple dual-port delay-line RAM: one write port, one registered read port (1-cycle latency).
// Contents are deliberately not reset so the array maps onto block RAM.
module audio_delay_ram #(
  parameter int WIDTH  = 48,
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 12
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/audio_stream_fx.sv
// One-sample-in-flight effect processor between codec read and write ports:
// pass, mute, L/R swap, or echo via a circular delay line with saturating mix.
module audio_stream_fx
  import audio_fx_pkg::*;
#(
  parameter int DATA_W      = 24,
  parameter int DELAY_LEN   = 4096,
  parameter int ATTEN_SHIFT = 1
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [1:0]        mode,
  audio_stream_fx_if.master codec,
  output logic              clip
);
  localparam int              ADDR_W    = $clog2(DELAY_LEN);
  localparam logic [ADDR_W:0] FILL_FULL = (ADDR_W+1)'(DELAY_LEN);

  state_e                   state_q, state_d;
  mode_e                    mode_q, mode_d;
  logic signed [DATA_W-1:0] in_l_q, in_l_d, in_r_q, in_r_d;
  logic signed [DATA_W-1:0] wd_l_q, wd_l_d, wd_r_q, wd_r_d;
  logic [ADDR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]          fill_q, fill_d;
  logic                     clip_q, clip_d;
  logic                     rd_stb, wr_stb, ram_re, ram_we;
  logic [2*DATA_W-1:0]      ram_rdata;
  logic signed [DATA_W-1:0] dly_l, dly_r, echo_l, echo_r;
  logic                     sat_l, sat_r;

  audio_delay_ram #(
    .WIDTH  (2*DATA_W),
    .DEPTH  (DELAY_LEN),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (CLOCK_50),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q),
    .wdata_i ({in_l_q, in_r_q}),
    .re_i    (ram_re),
    .raddr_i (wr_ptr_q),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_PASS;
      in_l_q   <= '0;
      in_r_q   <= '0;
      wd_l_q   <= '0;
      wd_r_q   <= '0;
      wr_ptr_q <= '0;
      fill_q   <= '0;
      clip_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      in_l_q   <= in_l_d;
      in_r_q   <= in_r_d;
      wd_l_q   <= wd_l_d;
      wd_r_q   <= wd_r_d;
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
      clip_q   <= clip_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    in_l_d   = in_l_q;
    in_r_d   = in_r_q;
    wd_l_d   = wd_l_q;
    wd_r_d   = wd_r_q;
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    clip_d   = clip_q;
    rd_stb   = 1'b0;
    wr_stb   = 1'b0;
    ram_re   = 1'b0;
    ram_we   = 1'b0;

    // The delayed sample only counts once the line holds a full DELAY_LEN of history.
    dly_l  = (fill_q == FILL_FULL) ? ram_rdata[2*DATA_W-1:DATA_W] : '0;
    dly_r  = (fill_q == FILL_FULL) ? ram_rdata[DATA_W-1:0]        : '0;
    echo_l = DATA_W'(sat_add(SAT_W'(in_l_q), SAT_W'(dly_l >>> ATTEN_SHIFT), DATA_W, sat_l));
    echo_r = DATA_W'(sat_add(SAT_W'(in_r_q), SAT_W'(dly_r >>> ATTEN_SHIFT), DATA_W, sat_r));

    case (state_q)
      ST_IDLE: begin
        if (codec.read_ready) begin
          rd_stb  = 1'b1;
          in_l_d  = codec.readdata_left;
          in_r_d  = codec.readdata_right;
          mode_d  = mode_e'(mode);
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        ram_re  = 1'b1;
        state_d = ST_MIX;
      end
      ST_MIX: begin
        case (mode_q)
          MODE_PASS: begin
            wd_l_d = in_l_q;
            wd_r_d = in_r_q;
          end
          MODE_MUTE: begin
            wd_l_d = '0;
            wd_r_d = '0;
          end
          MODE_SWAP: begin
            wd_l_d = in_r_q;
            wd_r_d = in_l_q;
          end
          MODE_ECHO: begin
            wd_l_d = echo_l;
            wd_r_d = echo_r;
            if (sat_l || sat_r) begin
              clip_d = 1'b1;
            end
          end
        endcase
        // The raw pair is stored in every mode so echo history survives mode changes.
        ram_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        if (fill_q != FILL_FULL) begin
          fill_d = fill_q + (ADDR_W+1)'(1);
        end
        state_d  = ST_SEND;
      end
      ST_SEND: begin
        if (codec.write_ready) begin
          wr_stb  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign codec.read            = rd_stb & ~reset;
  assign codec.write           = wr_stb & ~reset;
  assign codec.writedata_left  = wd_l_q;
  assign codec.writedata_right = wd_r_q;
  assign clip                  = clip_q;
endmodule

// File: tb/tb_audio_stream_fx.sv
// Bench for audio_stream_fx with a 4-deep delay line; a queue-based reference model
// tracks the last DELAY_LEN raw inputs and predicts every output sample and the clip flag.
module tb_audio_stream_fx;
  localparam int DW = 24;
  localparam int DL = 4;
  localparam int SH = 1;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic [1:0] mode;
  logic       clip;
  int         cyc = 0;
  int         n_vec = 0;
  int         n_err = 0;

  logic [2*DW-1:0] hist[$];
  bit              m_clip;

  audio_stream_fx_if #(.DATA_W(DW)) cif ();

  audio_stream_fx #(
    .DATA_W      (DW),
    .DELAY_LEN   (DL),
    .ATTEN_SHIFT (SH)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .mode     (mode),
    .codec    (cif),
    .clip     (clip)
  );

  always #5 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    hist.delete();
    m_clip = 1'b0;
  endtask

  task automatic model_step(input logic [DW-1:0] l, input logic [DW-1:0] r, input logic [1:0] m,
                            output logic [DW-1:0] el, output logic [DW-1:0] er);
    longint il, ir, dl, dr, sl, sr, hi, lo;
    logic [2*DW-1:0] old;
    il = $signed(l);
    ir = $signed(r);
    dl = 0;
    dr = 0;
    if (hist.size() == DL) begin
      old = hist.pop_front();
      dl  = $signed(old[2*DW-1:DW]);
      dr  = $signed(old[DW-1:0]);
    end
    hist.push_back({l, r});
    hi = (longint'(1) << (DW - 1)) - 1;
    lo = -(longint'(1) << (DW - 1));
    sl = il + (dl >>> SH);
    sr = ir + (dr >>> SH);
    case (m)
      2'd0: begin el = l; er = r; end
      2'd1: begin el = '0; er = '0; end
      2'd2: begin el = r; er = l; end
      default: begin
        if (sl > hi) begin sl = hi; m_clip = 1'b1; end
        else if (sl < lo) begin sl = lo; m_clip = 1'b1; end
        if (sr > hi) begin sr = hi; m_clip = 1'b1; end
        else if (sr < lo) begin sr = lo; m_clip = 1'b1; end
        el = sl[DW-1:0];
        er = sr[DW-1:0];
      end
    endcase
  endtask

  function automatic logic [DW-1:0] rnd24();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 3))
      0:       return {4'b0111, v[19:0]};
      1:       return {4'b1000, v[19:0]};
      default: return v[DW-1:0];
    endcase
  endfunction

  // Presents one sample, waits for its read, holds write_ready low for 'hold' cycles,
  // and returns what the DUT wrote plus timing observations. Returns at the write negedge.
  task automatic run_sample(input logic [DW-1:0] l, input logic [DW-1:0] r, input logic [1:0] m,
                            input int hold, output logic [DW-1:0] gl, output logic [DW-1:0] gr,
                            output int rd_cyc, output int wr_cyc, output int lat,
                            output int extra_rd, output bit unstable, output bit to);
    logic [2*DW-1:0] ref_wd;
    bit got;
    gl = '0; gr = '0; rd_cyc = 0; wr_cyc = 0; lat = 0;
    extra_rd = 0; unstable = 1'b0; to = 1'b0; got = 1'b0; ref_wd = '0;
    cif.read_ready     = 1'b1;
    cif.readdata_left  = l;
    cif.readdata_right = r;
    mode               = m;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLOCK_50);
      if (cif.read) begin
        got    = 1'b1;
        rd_cyc = cyc;
        break;
      end
    end
    if (!got) begin
      to = 1'b1;
      return;
    end
    got = 1'b0;
    for (int k = 1; k <= hold + 10; k++) begin
      @(posedge CLOCK_50);
      #1;
      cif.write_ready = (k > hold);
      if (k == 1) begin
        cif.readdata_left  = ~l;
        cif.readdata_right = ~r;
        mode               = ~m;
      end
      @(negedge CLOCK_50);
      if (k == 3) ref_wd = {cif.writedata_left, cif.writedata_right};
      else if (k > 3 && {cif.writedata_left, cif.writedata_right} !== ref_wd) unstable = 1'b1;
      if (cif.write) begin
        gl     = cif.writedata_left;
        gr     = cif.writedata_right;
        lat    = k;
        wr_cyc = cyc;
        got    = 1'b1;
        break;
      end
      if (cif.read) extra_rd++;
    end
    if (!got) to = 1'b1;
  endtask

  task automatic go_idle();
    cif.read_ready = 1'b0;
    repeat (2) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic do_reset();
    cif.read_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge CLOCK_50);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cif.read_ready = 1'b1;
    cif.write_ready = 1'b1;
    cif.readdata_left = 24'h111111;
    cif.readdata_right = 24'h222222;
    mode = 2'd0;
    repeat (3) @(negedge CLOCK_50);
    n_vec++; if (cif.read !== 1'b0) begin n_err++; $display("FAIL reset_read got=%b exp=0", cif.read); end
    n_vec++; if (cif.write !== 1'b0) begin n_err++; $display("FAIL reset_write got=%b exp=0", cif.write); end
    n_vec++; if (cif.writedata_left !== '0) begin n_err++; $display("FAIL reset_wdl got=%h exp=0", cif.writedata_left); end
    n_vec++; if (cif.writedata_right !== '0) begin n_err++; $display("FAIL reset_wdr got=%h exp=0", cif.writedata_right); end
    n_vec++; if (clip !== 1'b0) begin n_err++; $display("FAIL reset_clip got=%b exp=0", clip); end
    @(posedge CLOCK_50);
    #1;
    cif.read_ready = 1'b0;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_pass();
    logic [DW-1:0] gl, gr, el, er;
    int rc, wc, lat, xr;
    bit us, to;
    model_step(24'h123456, 24'hFEDCBA, 2'd0, el, er);
    run_sample(24'h123456, 24'hFEDCBA, 2'd0, 0, gl, gr, rc, wc, lat, xr, us, to);
    n_vec++; if (to) begin n_err++; $display("FAIL pass_timeout got=timeout exp=write"); end
    n_vec++; if (lat != 3) begin n_err++; $display("FAIL pass_latency got=%0d exp=3", lat); end
    n_vec++; if (xr != 0) begin n_err++; $display("FAIL pass_single_read got=%0d extra exp=0", xr); end
    n_vec++; if (gl !== 24'h123456) begin n_err++; $display("FAIL pass_left got=%h exp=123456", gl); end
    n_vec++; if (gr !== 24'hFEDCBA) begin n_err++; $display("FAIL pass_right got=%h exp=fedcba", gr); end
    @(negedge CLOCK_50);
    n_vec++; if (cif.write !== 1'b0) begin n_err++; $display("FAIL pass_write_pulse got=%b exp=0", cif.write); end
    cif.read_ready = 1'b0;
    go_idle();
    model_step(24'h000000, 24'h000000, 2'd0, el, er);
    run_sample(24'h000000, 24'h000000, 2'd0, 0, gl, gr, rc, wc, lat, xr, us, to);
    go_idle();
  endtask

  task automatic test_mute_swap();
    logic [DW-1:0] gl, gr, el, er, l, r;
    int rc, wc, lat, xr;
    bit us, to;
    run_sample(24'h000100, 24'h000100, 2'd1, 0, gl, gr, rc, wc, lat, xr, us, to);
    model_step(24'h000100, 24'h000100, 2'd1, el, er);
    n_vec++; if ({gl, gr} !== 48'h0) begin n_err++; $display("FAIL mute got=%h/%h exp=0/0", gl, gr); end
    run_sample(24'h000001, 24'h000002, 2'd2, 0, gl, gr, rc, wc, lat, xr, us, to);
    model_step(24'h000001, 24'h000002, 2'd2, el, er);
    n_vec++; if ({gl, gr} !== {24'h000002, 24'h000001}) begin n_err++; $display("FAIL swap got=%h/%h exp=000002/000001", gl, gr); end
    for (int i = 0; i < 16; i++) begin
      l = rnd24();
      r = rnd24();
      model_step(l, r, 2'(i % 3), el, er);
      run_sample(l, r, 2'(i % 3), 0, gl, gr, rc, wc, lat, xr, us, to);
      n_vec++; if (to || gl !== el || gr !== er) begin n_err++; $display("FAIL simple_mode%0d got=%h/%h exp=%h/%h", i % 3, gl, gr, el, er); end
    end
    go_idle();
  endtask

  task automatic test_echo();
    logic [DW-1:0] exp_out [7] = '{24'h000100, 24'h0, 24'h0, 24'h0, 24'h000080, 24'h0, 24'h0};
    logic [DW-1:0] gl, gr, el, er, v;
    int rc, wc, lat, xr;
    bit us, to;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      v = (i == 0) ? 24'h000100 : 24'h0;
      model_step(v, v, 2'd3, el, er);
      run_sample(v, v, 2'd3, 0, gl, gr, rc, wc, lat, xr, us, to);
      n_vec++; if (to || gl !== exp_out[i] || gr !== exp_out[i]) begin n_err++; $display("FAIL echo_out%0d got=%h/%h exp=%h", i, gl, gr, exp_out[i]); end
    end
    go_idle();
  endtask

  task automatic test_saturation();
    logic [DW-1:0] gl, gr, el, er;
    int rc, wc, lat, xr;
    bit us, to;
    for (int i = 0; i < 5; i++) begin
      model_step(24'h7FFFFF, 24'h7FFFFF, 2'd3, el, er);
      run_sample(24'h7FFFFF, 24'h7FFFFF, 2'd3, 0, gl, gr, rc, wc, lat, xr, us, to);
      if (i == 3) begin
        n_vec++; if (clip !== m_clip) begin n_err++; $display("FAIL sat_clip_early got=%b exp=%b", clip, m_clip); end
      end
    end
    n_vec++; if (gl !== 24'h7FFFFF || gr !== 24'h7FFFFF) begin n_err++; $display("FAIL sat_pos got=%h/%h exp=7fffff", gl, gr); end
    n_vec++; if (clip !== 1'b1) begin n_err++; $display("FAIL sat_clip got=%b exp=1", clip); end
    for (int i = 0; i < 5; i++) begin
      model_step(24'h800000, 24'h800000, 2'd3, el, er);
      run_sample(24'h800000, 24'h800000, 2'd3, 0, gl, gr, rc, wc, lat, xr, us, to);
      n_vec++; if (to || gl !== el || gr !== er) begin n_err++; $display("FAIL sat_neg%0d got=%h/%h exp=%h/%h", i, gl, gr, el, er); end
    end
    n_vec++; if (gl !== 24'h800000) begin n_err++; $display("FAIL sat_neg_final got=%h exp=800000", gl); end
    n_vec++; if (clip !== 1'b1) begin n_err++; $display("FAIL sat_clip_sticky got=%b exp=1", clip); end
    go_idle();
  endtask

  task automatic test_random();
    logic [DW-1:0] gl, gr, el, er, l, r;
    logic [1:0] m;
    int rc, wc, lat, xr;
    bit us, to;
    do_reset();
    for (int i = 0; i < 80; i++) begin
      l = rnd24();
      r = rnd24();
      m = ($urandom_range(0, 1) == 1) ? 2'd3 : 2'($urandom_range(0, 3));
      model_step(l, r, m, el, er);
      run_sample(l, r, m, 0, gl, gr, rc, wc, lat, xr, us, to);
      n_vec++; if (to || gl !== el || gr !== er) begin n_err++; $display("FAIL random%0d mode=%0d got=%h/%h exp=%h/%h", i, m, gl, gr, el, er); end
    end
    n_vec++; if (clip !== m_clip) begin n_err++; $display("FAIL random_clip got=%b exp=%b", clip, m_clip); end
    go_idle();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] gl, gr, el, er, l, r;
    int rc, wc, lat, xr, rc2, wc2;
    bit us, to;
    l = rnd24();
    r = rnd24();
    model_step(l, r, 2'd2, el, er);
    run_sample(l, r, 2'd2, 20, gl, gr, rc, wc, lat, xr, us, to);
    n_vec++; if (to) begin n_err++; $display("FAIL bp_timeout got=timeout exp=write"); end
    n_vec++; if (xr != 0) begin n_err++; $display("FAIL bp_no_read got=%0d reads exp=0", xr); end
    n_vec++; if (us) begin n_err++; $display("FAIL bp_stable got=changed exp=stable"); end
    n_vec++; if (lat != 21) begin n_err++; $display("FAIL bp_latency got=%0d exp=21", lat); end
    n_vec++; if (gl !== el || gr !== er) begin n_err++; $display("FAIL bp_data got=%h/%h exp=%h/%h", gl, gr, el, er); end
    l = rnd24();
    r = rnd24();
    model_step(l, r, 2'd0, el, er);
    run_sample(l, r, 2'd0, 0, gl, gr, rc2, wc2, lat, xr, us, to);
    n_vec++; if (rc2 - wc != 1) begin n_err++; $display("FAIL bp_read_after_write got=%0d cycles exp=1", rc2 - wc); end
    n_vec++; if (to || gl !== el || gr !== er) begin n_err++; $display("FAIL bp_next_data got=%h/%h exp=%h/%h", gl, gr, el, er); end
    go_idle();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] gl, gr, el, er, l, r;
    int rc, wc, lat, xr, prev_rc;
    bit us, to;
    prev_rc = -1;
    for (int i = 0; i < 6; i++) begin
      l = rnd24();
      r = rnd24();
      model_step(l, r, 2'd3, el, er);
      run_sample(l, r, 2'd3, 0, gl, gr, rc, wc, lat, xr, us, to);
      n_vec++; if (to || gl !== el || gr !== er) begin n_err++; $display("FAIL b2b_data%0d got=%h/%h exp=%h/%h", i, gl, gr, el, er); end
      if (i > 0) begin
        n_vec++; if (rc - prev_rc != 4) begin n_err++; $display("FAIL b2b_period%0d got=%0d exp=4", i, rc - prev_rc); end
      end
      prev_rc = rc;
    end
    go_idle();
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] gl, gr, el, er, l, r;
    int rc, wc, lat, xr, wr_seen;
    bit us, to, got;
    got = 1'b0;
    wr_seen = 0;
    cif.write_ready    = 1'b0;
    cif.read_ready     = 1'b1;
    cif.readdata_left  = 24'h0ABCDE;
    cif.readdata_right = 24'h054321;
    mode               = 2'd0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLOCK_50);
      if (cif.read) begin got = 1'b1; break; end
    end
    n_vec++; if (!got) begin n_err++; $display("FAIL rstmid_read got=none exp=read"); end
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    n_vec++; if (cif.writedata_left !== 24'h0ABCDE) begin n_err++; $display("FAIL rstmid_held got=%h exp=0abcde", cif.writedata_left); end
    reset = 1'b1;
    cif.write_ready = 1'b1;
    #1;
    n_vec++; if (cif.read !== 1'b0 || cif.write !== 1'b0) begin n_err++; $display("FAIL rstmid_strobes got=%b%b exp=00", cif.read, cif.write); end
    n_vec++; if ({cif.writedata_left, cif.writedata_right} !== 48'h0) begin n_err++; $display("FAIL rstmid_wd got=%h/%h exp=0/0", cif.writedata_left, cif.writedata_right); end
    n_vec++; if (clip !== 1'b0) begin n_err++; $display("FAIL rstmid_clip got=%b exp=0", clip); end
    for (int i = 0; i < 3; i++) begin
      @(negedge CLOCK_50);
      if (cif.write) wr_seen++;
    end
    n_vec++; if (wr_seen != 0) begin n_err++; $display("FAIL rstmid_no_write got=%0d exp=0", wr_seen); end
    @(posedge CLOCK_50);
    #1;
    cif.read_ready = 1'b0;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < DL + 3; i++) begin
      l = rnd24();
      r = rnd24();
      model_step(l, r, 2'd3, el, er);
      run_sample(l, r, 2'd3, 0, gl, gr, rc, wc, lat, xr, us, to);
      n_vec++; if (to || gl !== el || gr !== er) begin n_err++; $display("FAIL rstmid_echo%0d got=%h/%h exp=%h/%h", i, gl, gr, el, er); end
      if (i < DL) begin
        n_vec++; if (gl !== l || gr !== r) begin n_err++; $display("FAIL rstmid_dry%0d got=%h/%h exp=%h/%h", i, gl, gr, l, r); end
      end
    end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_pass();
    test_mute_swap();
    test_echo();
    test_saturation();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_saturation();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/audio_stream_fx.md
Name: audio_stream_fx

Overview:
- Parametrised successor to the direct codec loopback: a sequential sample processor between audio_codec read-side and write-side ports.
- Pops one stereo sample from the codec and applies a selectable effect: passthrough, mute, channel swap, or echo using an on-chip circular delay line with saturating mix.
- Pushes the result back to the codec with a strict one-sample-in-flight handshake.
- Instantiated in the board top level in place of the combinational loopback assigns.

Parameters:
- DATA_W, 24, sample width per channel (signed two's complement).
- DELAY_LEN, 4096, echo delay in samples; must be a power of two, at least 4.
- ADDR_W, $clog2(DELAY_LEN), delay-line address width (derived, not overridden).
- ATTEN_SHIFT, 1, arithmetic right shift applied to the delayed sample before mixing.

Ports:
- CLOCK_50  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- mode  in  2  effect select: 0 pass, 1 mute, 2 swap L/R, 3 echo.
- read_ready  in  1  codec has an input sample available.
- readdata_left  in  DATA_W  codec input sample, left channel.
- readdata_right  in  DATA_W  codec input sample, right channel.
- read  out  1  one-cycle pop strobe to the codec.
- write_ready  in  1  codec can accept an output sample.
- write  out  1  one-cycle push strobe to the codec.
- writedata_left  out  DATA_W  output sample, left channel.
- writedata_right  out  DATA_W  output sample, right channel.
- clip  out  1  sticky flag: some echo mix saturated since reset.

Behaviour:
- Reset values: read=0, write=0, writedata_*=0, clip=0, FSM=IDLE, wr_ptr=0, fill=0. RAM contents are not cleared.
- FSM states: IDLE, FETCH, MIX, SEND.
- IDLE: if read_ready, assert read for exactly this cycle, capture readdata_* and mode into internal registers, and go to FETCH. Otherwise remain in IDLE.
- FETCH: issue the synchronous RAM read at wr_ptr; this returns the sample written DELAY_LEN samples ago. Go to MIX.
- MIX:
  - Compute the output from the latched mode (see mixing rules below) and register it into writedata_*.
  - Write the raw input pair (never the mixed pair) to RAM at wr_ptr, in every mode.
  - Update wr_ptr = (wr_ptr+1) mod DELAY_LEN, wrapping naturally.
  - Update fill = min(fill+1, DELAY_LEN).
  - Go to SEND.
- Mixing rules, per mode:
  - mode 0: output = input.
  - mode 1: output = 0.
  - mode 2: output L = input R, output R = input L.
  - mode 3: d = (fill==DELAY_LEN) ? RAM_out : 0. Per channel, sum = sext(in, DATA_W+1) + sext(d >>> ATTEN_SHIFT, DATA_W+1). Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. If either channel saturates, set clip=1.
- SEND: writedata_* hold stable. When write_ready=1, assert write for this cycle and go to IDLE. Otherwise wait indefinitely, without asserting read.
- Latency: read at cycle N, earliest write at N+3. Maximum throughput is one sample per 4 cycles, far above the 48 kHz codec rate.
- read and write are never asserted in the same cycle, and each is never high for two consecutive cycles.
- mode changes take effect on the next read; the sample in flight uses its latched mode.
- The echo history is continuous across mode changes, because the delay line is written in every mode.
- Simultaneous read_ready and write_ready while in IDLE: read wins, since nothing is pending.
- Reset asserted mid-operation: all state returns to reset values immediately. An in-flight sample is dropped, with no write pulse. fill=0, so echo output is dry until DELAY_LEN new samples have been written.
- writedata_* are registered outputs and keep their last value after write, until the next MIX.

Decomposition:
- Package audio_fx_pkg holds:
  - mode encodings MODE_PASS=0, MODE_MUTE=1, MODE_SWAP=2, MODE_ECHO=3;
  - the FSM state enum;
  - the saturating-add function, parametrised by width.
- Sub-module audio_delay_ram: simple dual-port synchronous RAM, 2*DATA_W wide by DELAY_LEN deep. It has one write port and one registered read port with 1-cycle latency, and no reset on its contents, so it infers block RAM.

Test Plan:
- Passthrough, mode=0: present L=24'h123456, R=24'hFEDCBA with read_ready and write_ready held high. Require read for 1 cycle, then write exactly 3 cycles later, with writedata L=24'h123456, R=24'hFEDCBA.
- Mute and swap: mode=1 with input L=24'h000100 -> both outputs 0. mode=2 with L=24'h000001, R=24'h000002 -> L=24'h000002, R=24'h000001.
- Echo, DELAY_LEN=4, ATTEN_SHIFT=1, mode=3: feed L=R=24'h000100, then six samples of 0. Require:
  - outputs 0x100 followed by three zeros (fill not yet full);
  - then 0x080 on the 5th output (the sample written 4 samples earlier, shifted right by 1);
  - then 0.
- Saturation: with DELAY_LEN=4, feed 24'h7FFFFF for 5 samples in echo mode. Require the 5th output = 24'h7FFFFF and clip=1, with clip still 1 afterwards. A negative stream of 24'h800000 must give 24'h800000.
- Backpressure: hold write_ready=0 for 20 cycles after MIX while read_ready=1. Require no further read, writedata stable, and a single write pulse when write_ready rises, followed by a read within 1 cycle.
- Reset mid-sample: assert reset during SEND. Require read, write, writedata_* and clip = 0 within the same cycle, with no write pulse. After release, echo output is dry for the first DELAY_LEN samples.
